// File: rtl/pipe_ctrl_decoder.sv
// rtl/pipe_ctrl_decoder.sv - registered ID->EX control decoder with mult/div busy tracking
module pipe_ctrl_decoder #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        stall_in,
  input  logic        flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic        ex_branch,
  output logic [1:0]  ex_br,
  output logic        ex_bne,
  output logic [1:0]  ex_regin,
  output logic        ex_regwr,
  output logic [1:0]  ex_extop,
  output logic        ex_alusrc,
  output logic [3:0]  ex_aluop,
  output logic        ex_memwr,
  output logic [1:0]  ex_toreg,
  output logic        ex_cp0wr,
  output logic        ex_ri,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        md_busy,
  output logic        md_done
);

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic [1:0] br;
    logic       bne;
    logic [1:0] regin;
    logic       regwr;
    logic [1:0] extop;
    logic       alusrc;
    logic [3:0] aluop;
    logic       memwr;
    logic [1:0] toreg;
    logic       cp0wr;
    logic       ri;
  } ctrl_t;

  ctrl_t            dec, ex_d, ex_q;
  logic             dec_md, dec_hilo;
  logic [5:0]       op, funct;
  logic [4:0]       rs;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             md_start_d, md_start_q;
  logic [1:0]       md_op_d, md_op_q;
  logic             md_hazard, id_stall;

  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign funct = id_instr[5:0];

  always_comb begin
    dec      = '0;
    dec.valid = 1'b1;
    dec_md   = 1'b0;
    dec_hilo = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          // sll with an all-zero word is the canonical nop: keep it valid but non-writing
          6'h00: begin dec.regin = 2'd1; dec.regwr = |id_instr; dec.aluop = 4'd8; end
          6'h08: begin dec.branch = 1'b1; dec.br = 2'd2; end
          6'h09: begin dec.branch = 1'b1; dec.br = 2'd2; dec.regin = 2'd1; dec.regwr = 1'b1; dec.toreg = 2'd2; end
          6'h10, 6'h12: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.toreg = 2'd3; dec_hilo = 1'b1; end
          6'h11, 6'h13: dec_hilo = 1'b1;
          6'h18, 6'h19, 6'h1A, 6'h1B: dec_md = 1'b1;
          6'h21: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd0; end
          6'h23: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd1; end
          6'h24: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd3; end
          6'h25: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd2; end
          6'h26: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd4; end
          6'h27: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd5; end
          6'h2A: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd6; end
          6'h2B: begin dec.regin = 2'd1; dec.regwr = 1'b1; dec.aluop = 4'd7; end
          default: dec.ri = 1'b1;
        endcase
      end
      6'h02: begin dec.branch = 1'b1; dec.br = 2'd1; end
      6'h03: begin dec.branch = 1'b1; dec.br = 2'd1; dec.regin = 2'd2; dec.regwr = 1'b1; dec.toreg = 2'd2; end
      6'h04: begin dec.branch = 1'b1; dec.extop = 2'd1; dec.aluop = 4'd1; end
      6'h05: begin dec.branch = 1'b1; dec.bne = 1'b1; dec.extop = 2'd1; dec.aluop = 4'd1; end
      6'h09: begin dec.regwr = 1'b1; dec.extop = 2'd1; dec.alusrc = 1'b1; dec.aluop = 4'd0; end
      6'h0C: begin dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.aluop = 4'd3; end
      6'h0D: begin dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.aluop = 4'd2; end
      6'h0F: begin dec.regwr = 1'b1; dec.extop = 2'd2; dec.alusrc = 1'b1; dec.aluop = 4'd0; end
      6'h23: begin dec.regwr = 1'b1; dec.extop = 2'd1; dec.alusrc = 1'b1; dec.toreg = 2'd1; end
      6'h2B: begin dec.memwr = 1'b1; dec.extop = 2'd1; dec.alusrc = 1'b1; end
      6'h10: begin
        if (rs == 5'h00) begin
          dec.regwr = 1'b1;
          dec.toreg = 2'd1;
        end else if (rs == 5'h04) begin
          dec.cp0wr = 1'b1;
        end else if (rs == 5'h10 && funct == 6'h18) begin
          dec.branch = 1'b1;
          dec.br     = 2'd3;
        end else begin
          dec.ri = 1'b1;
        end
      end
      default: dec.ri = 1'b1;
    endcase
  end

  assign md_busy   = (cnt_q != '0);
  assign md_done   = (cnt_q == CNT_W'(1));
  assign md_hazard = md_busy & id_valid & (dec_md | dec_hilo);
  assign id_stall  = stall_in | md_hazard;
  assign id_ready  = ~id_stall;

  always_comb begin
    ex_d       = '0;
    md_start_d = 1'b0;
    md_op_d    = md_op_q;
    cnt_d      = cnt_q;
    if (!flush && !id_stall && id_valid) begin
      ex_d       = dec;
      md_start_d = dec_md;
    end
    // an in-flight operation is never aborted by flush; only reset clears the counter
    if (md_start_d) begin
      md_op_d = funct[1:0];
      cnt_d   = funct[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q       <= '0;
      cnt_q      <= '0;
      md_start_q <= 1'b0;
      md_op_q    <= 2'd0;
    end else begin
      ex_q       <= ex_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
      md_op_q    <= md_op_d;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign ex_branch = ex_q.branch;
  assign ex_br     = ex_q.br;
  assign ex_bne    = ex_q.bne;
  assign ex_regin  = ex_q.regin;
  assign ex_regwr  = ex_q.regwr;
  assign ex_extop  = ex_q.extop;
  assign ex_alusrc = ex_q.alusrc;
  assign ex_aluop  = ex_q.aluop;
  assign ex_memwr  = ex_q.memwr;
  assign ex_toreg  = ex_q.toreg;
  assign ex_cp0wr  = ex_q.cp0wr;
  assign ex_ri     = ex_q.ri;
  assign md_start  = md_start_q;
  assign md_op     = md_op_q;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// tb/tb_pipe_ctrl_decoder.sv - self-checking bench for pipe_ctrl_decoder
module tb_pipe_ctrl_decoder;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = 32'h0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        id_ready, ex_valid, ex_branch, ex_bne, ex_regwr, ex_alusrc, ex_memwr, ex_cp0wr, ex_ri;
  logic [1:0]  ex_br, ex_regin, ex_extop, ex_toreg, md_op;
  logic [3:0]  ex_aluop;
  logic        md_start, md_busy, md_done;

  pipe_ctrl_decoder #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .stall_in(stall_in), .flush(flush), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_br(ex_br), .ex_bne(ex_bne), .ex_regin(ex_regin),
    .ex_regwr(ex_regwr), .ex_extop(ex_extop), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_memwr(ex_memwr), .ex_toreg(ex_toreg), .ex_cp0wr(ex_cp0wr), .ex_ri(ex_ri),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       branch;
    logic [1:0] br;
    logic       bne;
    logic [1:0] regin;
    logic       regwr;
    logic [1:0] extop;
    logic       alusrc;
    logic [3:0] aluop;
    logic       memwr;
    logic [1:0] toreg;
    logic       cp0wr;
  } fld_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // mnemonic table: first entry whose masked bits match wins; cls 0 plain, 1 mult/div, 2 hi/lo move
  logic [31:0] t_mask [48];
  logic [31:0] t_val  [48];
  int          t_cls  [48];
  logic [1:0]  t_op   [48];
  int          t_len  [48];
  fld_t        t_f    [48];
  int          t_n = 0;

  function automatic fld_t mk(input int b, input int br, input int bn, input int rg, input int wr,
                              input int ex, input int src, input int alu, input int mw, input int tr,
                              input int c0);
    fld_t f;
    f.branch = 1'(b);  f.br = 2'(br);   f.bne = 1'(bn);  f.regin = 2'(rg); f.regwr = 1'(wr);
    f.extop = 2'(ex);  f.alusrc = 1'(src); f.aluop = 4'(alu); f.memwr = 1'(mw);
    f.toreg = 2'(tr);  f.cp0wr = 1'(c0);
    return f;
  endfunction

  task automatic add(input logic [31:0] m, input logic [31:0] v, input int cls, input int op, input fld_t f);
    t_mask[t_n] = m; t_val[t_n] = v; t_cls[t_n] = cls; t_op[t_n] = 2'(op); t_f[t_n] = f;
    t_len[t_n] = (cls == 1) ? ((op >= 2) ? DIV_N : MULT_N) : 0;
    t_n++;
  endtask

  function automatic int lookup(input logic [31:0] ins);
    for (int i = 0; i < t_n; i++)
      if ((ins & t_mask[i]) == t_val[i]) return i;
    return -1;
  endfunction

  // behavioural model: E contents plus the absolute cycle window during which mult/div is busy
  logic m_valid = 1'b0, m_ri = 1'b0, m_start = 1'b0;
  fld_t m_f = '0;
  logic [1:0] m_op = 2'd0;
  int cyc = 0, md_begin = -100, md_len = 1;

  function automatic logic mbusy();
    return (cyc >= md_begin) && (cyc < md_begin + md_len);
  endfunction

  function automatic logic hz();
    int k;
    k = lookup(id_instr);
    return mbusy() && id_valid && (k >= 0) && (t_cls[k] != 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0; m_ri <= 1'b0; m_start <= 1'b0; m_f <= '0; m_op <= 2'd0;
      md_begin <= -100; md_len <= 1;
    end else begin
      cyc <= cyc + 1;
      m_start <= 1'b0;
      if (flush || stall_in || hz() || !id_valid) begin
        m_valid <= 1'b0; m_ri <= 1'b0; m_f <= '0;
      end else if (lookup(id_instr) < 0) begin
        m_valid <= 1'b1; m_ri <= 1'b1; m_f <= '0;
      end else begin
        m_valid <= 1'b1; m_ri <= 1'b0; m_f <= t_f[lookup(id_instr)];
        if (t_cls[lookup(id_instr)] == 1) begin
          m_start  <= 1'b1;
          m_op     <= t_op[lookup(id_instr)];
          md_begin <= cyc + 1;
          md_len   <= t_len[lookup(id_instr)];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ex_valid", ex_valid, m_valid);     chk("ex_ri", ex_ri, m_ri);
    chk("ex_branch", ex_branch, m_f.branch); chk("ex_br", ex_br, m_f.br);
    chk("ex_bne", ex_bne, m_f.bne);          chk("ex_regin", ex_regin, m_f.regin);
    chk("ex_regwr", ex_regwr, m_f.regwr);    chk("ex_extop", ex_extop, m_f.extop);
    chk("ex_alusrc", ex_alusrc, m_f.alusrc); chk("ex_aluop", ex_aluop, m_f.aluop);
    chk("ex_memwr", ex_memwr, m_f.memwr);    chk("ex_toreg", ex_toreg, m_f.toreg);
    chk("ex_cp0wr", ex_cp0wr, m_f.cp0wr);    chk("md_start", md_start, m_start);
    chk("md_op", md_op, m_op);               chk("md_busy", md_busy, mbusy());
    chk("md_done", md_done, mbusy() && (cyc == md_begin + md_len - 1));
    chk("id_ready", id_ready, !(stall_in || hz()));
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    @(negedge clk);
    #1;
    id_valid = v; id_instr = ins; stall_in = st; flush = fl;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep [0:24] = '{
    32'h03E00008, 32'h0020F809, 32'h08000010, 32'h0C000010, 32'h34220005,
    32'h30220005, 32'h2422FFFF, 32'hAC220004, 32'h40026000, 32'h40826000,
    32'h42000018, 32'h00221823, 32'h00221824, 32'h00221825, 32'h00221826,
    32'h00221827, 32'h0022182A, 32'h0022182B, 32'h00001010, 32'h00200011,
    32'h00200013, 32'h0000003F, 32'h40200000, 32'h8C220004, 32'h00011080
  };

  int starts, busy_n, done_n, rdy_lo, done_at, last_busy;

  initial begin
    add(32'hFFFFFFFF, 32'h00000000, 0, 0, mk(0,0,0,1,0,0,0,8,0,0,0));
    add(32'hFC00003F, 32'h00000000, 0, 0, mk(0,0,0,1,1,0,0,8,0,0,0));
    add(32'hFC00003F, 32'h00000008, 0, 0, mk(1,2,0,0,0,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h00000009, 0, 0, mk(1,2,0,1,1,0,0,0,0,2,0));
    add(32'hFC00003F, 32'h00000010, 2, 0, mk(0,0,0,1,1,0,0,0,0,3,0));
    add(32'hFC00003F, 32'h00000011, 2, 0, mk(0,0,0,0,0,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h00000012, 2, 0, mk(0,0,0,1,1,0,0,0,0,3,0));
    add(32'hFC00003F, 32'h00000013, 2, 0, mk(0,0,0,0,0,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h00000018, 1, 0, mk(0,0,0,0,0,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h00000019, 1, 1, mk(0,0,0,0,0,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h0000001A, 1, 2, mk(0,0,0,0,0,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h0000001B, 1, 3, mk(0,0,0,0,0,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h00000021, 0, 0, mk(0,0,0,1,1,0,0,0,0,0,0));
    add(32'hFC00003F, 32'h00000023, 0, 0, mk(0,0,0,1,1,0,0,1,0,0,0));
    add(32'hFC00003F, 32'h00000024, 0, 0, mk(0,0,0,1,1,0,0,3,0,0,0));
    add(32'hFC00003F, 32'h00000025, 0, 0, mk(0,0,0,1,1,0,0,2,0,0,0));
    add(32'hFC00003F, 32'h00000026, 0, 0, mk(0,0,0,1,1,0,0,4,0,0,0));
    add(32'hFC00003F, 32'h00000027, 0, 0, mk(0,0,0,1,1,0,0,5,0,0,0));
    add(32'hFC00003F, 32'h0000002A, 0, 0, mk(0,0,0,1,1,0,0,6,0,0,0));
    add(32'hFC00003F, 32'h0000002B, 0, 0, mk(0,0,0,1,1,0,0,7,0,0,0));
    add(32'hFC000000, 32'h08000000, 0, 0, mk(1,1,0,0,0,0,0,0,0,0,0));
    add(32'hFC000000, 32'h0C000000, 0, 0, mk(1,1,0,2,1,0,0,0,0,2,0));
    add(32'hFC000000, 32'h10000000, 0, 0, mk(1,0,0,0,0,1,0,1,0,0,0));
    add(32'hFC000000, 32'h14000000, 0, 0, mk(1,0,1,0,0,1,0,1,0,0,0));
    add(32'hFC000000, 32'h24000000, 0, 0, mk(0,0,0,0,1,1,1,0,0,0,0));
    add(32'hFC000000, 32'h30000000, 0, 0, mk(0,0,0,0,1,0,1,3,0,0,0));
    add(32'hFC000000, 32'h34000000, 0, 0, mk(0,0,0,0,1,0,1,2,0,0,0));
    add(32'hFC000000, 32'h3C000000, 0, 0, mk(0,0,0,0,1,2,1,0,0,0,0));
    add(32'hFC000000, 32'h8C000000, 0, 0, mk(0,0,0,0,1,1,1,0,0,1,0));
    add(32'hFC000000, 32'hAC000000, 0, 0, mk(0,0,0,0,0,1,1,0,1,0,0));
    add(32'hFFE00000, 32'h40000000, 0, 0, mk(0,0,0,0,1,0,0,0,0,1,0));
    add(32'hFFE00000, 32'h40800000, 0, 0, mk(0,0,0,0,0,0,0,0,0,0,1));
    add(32'hFE00003F, 32'h42000018, 0, 0, mk(1,3,0,0,0,0,0,0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0); chk("rst_md_busy", md_busy, 0);
    chk("rst_md_op", md_op, 0);       chk("rst_id_ready", id_ready, 1);
    @(negedge clk); #1; reset = 1'b1;

    drive(1, 32'h00221821, 0, 0); edge1();
    chk("addu_valid", ex_valid, 1); chk("addu_regwr", ex_regwr, 1); chk("addu_regin", ex_regin, 1);
    chk("addu_aluop", ex_aluop, 0); chk("addu_alusrc", ex_alusrc, 0); chk("addu_toreg", ex_toreg, 0);
    drive(1, 32'h3C011234, 0, 0); edge1();
    chk("lui_extop", ex_extop, 2); chk("lui_alusrc", ex_alusrc, 1);
    chk("lui_regwr", ex_regwr, 1); chk("lui_regin", ex_regin, 0);
    drive(1, 32'h10220003, 0, 0); edge1();
    chk("beq_branch", ex_branch, 1); chk("beq_br", ex_br, 0); chk("beq_bne", ex_bne, 0);
    drive(1, 32'h14220003, 0, 0); edge1();
    chk("bne_bne", ex_bne, 1);
    drive(1, 32'hFC000000, 0, 0); edge1();
    chk("ri_ri", ex_ri, 1); chk("ri_regwr", ex_regwr, 0); chk("ri_memwr", ex_memwr, 0);
    chk("ri_cp0wr", ex_cp0wr, 0); chk("ri_valid", ex_valid, 1);
    drive(1, 32'h00000000, 0, 0); edge1();
    chk("nop_valid", ex_valid, 1); chk("nop_regwr", ex_regwr, 0);

    for (int i = 0; i < 25; i++) drive(1, sweep[i], 0, 0);
    drive(0, 32'h00221821, 0, 0);
    drive(1, 32'h00221821, 1, 0);

    drive(1, 32'h00220018, 0, 0);
    drive(1, 32'h00001012, 0, 0);
    starts = 0; busy_n = 0; done_n = 0; rdy_lo = 0; done_at = -1; last_busy = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (md_start) starts++;
      if (md_busy) begin busy_n++; last_busy = i; end
      if (md_done) begin done_n++; done_at = i; end
      if (!id_ready) rdy_lo++;
      @(negedge clk);
    end
    chk("mult_starts", 32'(starts), 1); chk("mult_busy_cycles", 32'(busy_n), 5);
    chk("mult_done_count", 32'(done_n), 1); chk("mult_done_last", 32'(done_at), 32'(last_busy));
    chk("mult_ready_low", 32'(rdy_lo), 5);
    #1;
    chk("mflo_toreg", ex_toreg, 3); chk("mflo_regwr", ex_regwr, 1);

    drive(1, 32'h00220019, 0, 0);
    drive(1, 32'h00221821, 0, 1); edge1();
    chk("flush_keeps_busy", md_busy, 1);
    repeat (6) drive(1, 32'h0022001A, 0, 0);
    repeat (12) drive(0, 32'h0, 0, 0);

    drive(1, 32'h8C220004, 1, 1); edge1();
    chk("lw_flush_bubble", ex_valid, 0);
    drive(1, 32'h8C220004, 0, 0); edge1();
    chk("lw_toreg", ex_toreg, 1); chk("lw_extop", ex_extop, 1); chk("lw_valid", ex_valid, 1);

    drive(1, 32'h0022001A, 0, 0);
    drive(1, 32'h00221821, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("div_busy_pre", md_busy, 1); chk("div_op_pre", md_op, 2); chk("div_exv_pre", ex_valid, 1);
    reset = 1'b0;
    #1;
    chk("div_rst_busy", md_busy, 0); chk("div_rst_exv", ex_valid, 0); chk("div_rst_regwr", ex_regwr, 0);
    chk("div_rst_op", md_op, 0);     chk("div_rst_done", md_done, 0);
    @(negedge clk); #1;
    reset = 1'b1; id_valid = 1'b0;
    #1;
    chk("rel_id_ready", id_ready, 1);
    repeat (3) drive(0, 32'h0, 0, 0);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
